fib_mm2s_reader: RTL and testbench
==================================

// Module: fib_mm2s_reader
// PURPOSE
//  Read-back checker for the Fibonacci DataMover test path. Issues two MM2S
//  commands to the AXI DataMover and receives the 256-bit read stream. Checks
//  every beat against a Fibonacci sequence generated on the fly, then checks
//  the MM2S status words. Reports done, pass and error count to the host.
// PARAMETERS
//  ADDR1    64'h0A00_0000  source address, transfer 1 (words 0..BEATS1-1)
//  ADDR2    64'h0010_0000  source address, transfer 2 (words BEATS1..BEATS1+BEATS2-1)
//  BEATS1   8              beats in transfer 1 (BTT = BEATS1*32 bytes)
//  BEATS2   17             beats in transfer 2 (BTT = BEATS2*32 bytes)
//  TIMEOUT  1024           max idle cycles in any wait state before abort
// PORTS
//  clk                     in   1    clock
//  rst_n                   in   1    synchronous reset, active-low
//  ap_start                in   1    level start request
//  ap_done                 out  1    run finished; held until ap_start low
//  ap_pass                 out  1    valid while ap_done=1; 1 = zero errors
//  err_cnt                 out  8    errors counted this run, saturates at 255
//  s_axis_mm2s_cmd_tvalid  out  1    command valid
//  s_axis_mm2s_cmd_tready  in   1    command ready
//  s_axis_mm2s_cmd_tdata   out  104  command word
//  m_axis_mm2s_tvalid      in   1    read data valid
//  m_axis_mm2s_tready      out  1    read data ready
//  m_axis_mm2s_tdata       in   256  read data
//  m_axis_mm2s_tkeep       in   32   byte enables
//  m_axis_mm2s_tlast       in   1    end of transfer
//  m_axis_mm2s_sts_tvalid  in   1    status valid
//  m_axis_mm2s_sts_tready  out  1    status ready
//  m_axis_mm2s_sts_tdata   in   8    status [7]OKAY [6]SLVERR [5]DECERR [4]INTERR [3:0]tag
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE. err_cnt, word index and golden regs are cleared.
//  Reset mid-run aborts immediately. No command is reissued until a new ap_start.
//  Command word: {8'h00, ADDRn[63:0], 8'h40 (EOF=1), 1'b1 (INCR), BTTn[22:0]}.
//  FSM: IDLE->CMD1->DATA1->STS1->CMD2->DATA2->STS2->DONE->IDLE.
//   IDLE: leave when ap_start=1. Clear err_cnt, word index and golden (a=0, b=1).
//   CMDn: cmd_tvalid=1 starting the cycle after entry. tvalid/tdata are held
//     stable until cmd_tready=1. Transfer happens on tvalid&tready; then go to DATAn.
//   DATAn: tready=1. A beat is accepted on tvalid&tready.
//     Each accepted beat is checked:
//       tdata != a                         -> +1 error
//       tkeep != all-ones                  -> +1 error
//       tlast != (beat is last of transfer) -> +1 error
//     At most 1 error per beat, even if several checks fail.
//     After each beat: a<=b, b<=a+b (mod 2^256), index+1.
//     Leave to STSn after BEATSn beats, whatever tlast says.
//   STSn: sts_tready=1. Accept one status word.
//     Error if OKAY=0 or any of bits [6:4] set (+1 error). Then go to the next state.
//   DONE: ap_done=1 and ap_pass=(err_cnt==0). Return to IDLE when ap_start=0.
//     ap_done drops in the same cycle the FSM enters IDLE.
//  Watchdog: counter cleared on every state change and every handshake.
//   If it reaches TIMEOUT in CMDn/DATAn/STSn: +1 error, then go to DONE (ap_pass=0).
//  m_axis_mm2s_tready=0 and sts_tready=0 outside their states.
//  Beats and status words arriving early are therefore stalled, not dropped.
//  err_cnt saturates at 255. Word index is 5 bits.
// TESTING
//  1 Normal run, no backpressure, correct fib(0..24) (last beat 46368).
//    -> 2 commands (BTT 256, 544); ap_done=1, ap_pass=1, err_cnt=0.
//  2 Hold cmd_tready low for 5 cycles during CMD1.
//    -> cmd_tvalid stays 1 and tdata stays unchanged; exactly one handshake per command.
//  3 Corrupt word 12 to 0 and randomise tvalid gaps.
//    -> err_cnt=1, ap_pass=0; later words still pass (golden stays aligned).
//  4 tlast on beat 5 of transfer 1 and missing on beat 7.
//    -> err_cnt=2; FSM leaves DATA1 only after 8 beats.
//  5 Status 8'h40 (SLVERR, OKAY=0) for transfer 2.
//    -> err_cnt=1, ap_pass=0.
//  6 No data after CMD2 -> abort TIMEOUT cycles later with ap_pass=0.
//    Separately, rst_n low mid-DATA2 -> all outputs 0 next cycle, then FSM waits in IDLE.

Source files
------------

// File: rtl/fib_mm2s_reader_if.sv
// fib_mm2s_reader_if
//   Bundles the three AXI-Stream channels between the Fibonacci read-back
//   checker and the AXI DataMover MM2S side.
//   Channels:
//     s_axis_mm2s_cmd_*  104-bit command (checker -> DataMover)
//     m_axis_mm2s_*      256-bit read data with tkeep/tlast (DataMover -> checker)
//     m_axis_mm2s_sts_*  8-bit status word (DataMover -> checker)
//   Modports:
//     master  the checker (issues commands, consumes data and status)
//     slave   the DataMover side (or a bench model of it)
interface fib_mm2s_reader_if;
  logic         s_axis_mm2s_cmd_tvalid;
  logic         s_axis_mm2s_cmd_tready;
  logic [103:0] s_axis_mm2s_cmd_tdata;
  logic         m_axis_mm2s_tvalid;
  logic         m_axis_mm2s_tready;
  logic [255:0] m_axis_mm2s_tdata;
  logic [31:0]  m_axis_mm2s_tkeep;
  logic         m_axis_mm2s_tlast;
  logic         m_axis_mm2s_sts_tvalid;
  logic         m_axis_mm2s_sts_tready;
  logic [7:0]   m_axis_mm2s_sts_tdata;

  modport master (
    output s_axis_mm2s_cmd_tvalid, s_axis_mm2s_cmd_tdata,
    input  s_axis_mm2s_cmd_tready,
    input  m_axis_mm2s_tvalid, m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast,
    output m_axis_mm2s_tready,
    input  m_axis_mm2s_sts_tvalid, m_axis_mm2s_sts_tdata,
    output m_axis_mm2s_sts_tready
  );

  modport slave (
    input  s_axis_mm2s_cmd_tvalid, s_axis_mm2s_cmd_tdata,
    output s_axis_mm2s_cmd_tready,
    output m_axis_mm2s_tvalid, m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast,
    input  m_axis_mm2s_tready,
    output m_axis_mm2s_sts_tvalid, m_axis_mm2s_sts_tdata,
    input  m_axis_mm2s_sts_tready
  );
endinterface

// File: rtl/fib_mm2s_reader.sv
// fib_mm2s_reader
//   Read-back checker for the Fibonacci DataMover test path. Issues two MM2S
//   commands, checks every returned 256-bit beat against a Fibonacci sequence
//   generated on the fly, then checks each MM2S status word. A watchdog aborts
//   any wait state that stalls for TIMEOUT cycles.
//   Ports:
//     clk       clock
//     rst_n     synchronous reset, active-low
//     ap_start  level start request
//     ap_done   run finished, held until ap_start drops
//     ap_pass   valid while ap_done; 1 = no errors this run
//     err_cnt   errors this run, saturating at 255
//     bus       MM2S command / data / status channels (master modport)
module fib_mm2s_reader #(
  parameter logic [63:0] ADDR1   = 64'h0A00_0000,
  parameter logic [63:0] ADDR2   = 64'h0010_0000,
  parameter int          BEATS1  = 8,
  parameter int          BEATS2  = 17,
  parameter int          TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_pass,
  output logic [7:0]        err_cnt,
  fib_mm2s_reader_if.master bus
);

  typedef enum logic [2:0] {IDLE, CMD1, DATA1, STS1, CMD2, DATA2, STS2, DONE} state_t;

  localparam int           WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [22:0]  BTT1  = 23'(BEATS1 * 32);
  localparam logic [22:0]  BTT2  = 23'(BEATS2 * 32);
  localparam logic [4:0]   LAST1 = 5'(BEATS1 - 1);
  localparam logic [4:0]   LAST2 = 5'(BEATS1 + BEATS2 - 1);
  // {reserved, address, EOF=1 (8'h40), INCR, bytes to transfer}
  localparam logic [103:0] CMD_W1 = {8'h00, ADDR1, 8'h40, 1'b1, BTT1};
  localparam logic [103:0] CMD_W2 = {8'h00, ADDR2, 8'h40, 1'b1, BTT2};

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t         state_q, state_d;
  logic           cmd_vld_q, cmd_vld_d;
  logic [103:0]   cmd_data_q, cmd_data_d;
  logic           dat_rdy_q, dat_rdy_d;
  logic           sts_rdy_q, sts_rdy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [7:0]     err_q, err_d;
  logic [4:0]     idx_q, idx_d;
  logic [255:0]   a_q, a_d;
  logic [255:0]   b_q, b_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic hs_cmd, hs_dat, hs_sts, hs_any, in_wait, is_last, beat_bad, sts_bad;
  logic unused_sts_tag;

  assign hs_cmd  = cmd_vld_q & bus.s_axis_mm2s_cmd_tready;
  assign hs_dat  = dat_rdy_q & bus.m_axis_mm2s_tvalid;
  assign hs_sts  = sts_rdy_q & bus.m_axis_mm2s_sts_tvalid;
  assign hs_any  = hs_cmd | hs_dat | hs_sts;
  assign in_wait = (state_q != IDLE) && (state_q != DONE);
  assign is_last = (state_q == DATA1) ? (idx_q == LAST1) : (idx_q == LAST2);
  // Several failing checks on one beat still count as a single error.
  assign beat_bad = (bus.m_axis_mm2s_tdata != a_q) ||
                    (bus.m_axis_mm2s_tkeep != '1) ||
                    (bus.m_axis_mm2s_tlast != is_last);
  assign sts_bad  = !bus.m_axis_mm2s_sts_tdata[7] || (|bus.m_axis_mm2s_sts_tdata[6:4]);
  assign unused_sts_tag = ^bus.m_axis_mm2s_sts_tdata[3:0];

  always_comb begin
    state_d    = state_q;
    cmd_vld_d  = cmd_vld_q;
    cmd_data_d = cmd_data_q;
    err_d      = err_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    wd_d       = wd_q;

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d = CMD1;
          err_d   = 8'd0;
          idx_d   = 5'd0;
          a_d     = '0;
          b_d     = 256'd1;
        end
      end
      CMD1, CMD2: begin
        // tvalid rises the cycle after entry and holds with its word until taken.
        if (!cmd_vld_q) begin
          cmd_vld_d  = 1'b1;
          cmd_data_d = (state_q == CMD1) ? CMD_W1 : CMD_W2;
        end else if (hs_cmd) begin
          cmd_vld_d = 1'b0;
          state_d   = (state_q == CMD1) ? DATA1 : DATA2;
        end
      end
      DATA1, DATA2: begin
        if (hs_dat) begin
          if (beat_bad) err_d = sat_inc(err_q);
          a_d   = b_q;
          b_d   = a_q + b_q;
          idx_d = idx_q + 5'd1;
          // Leave on the beat count; tlast only feeds the error check.
          if (is_last) state_d = (state_q == DATA1) ? STS1 : STS2;
        end
      end
      STS1, STS2: begin
        if (hs_sts) begin
          if (sts_bad) err_d = sat_inc(err_q);
          state_d = (state_q == STS1) ? CMD2 : DONE;
        end
      end
      DONE: begin
        if (!ap_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog: restarts on any progress, aborts a stalled wait state.
    if (state_d != state_q || hs_any) begin
      wd_d = '0;
    end else if (in_wait) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        err_d     = sat_inc(err_q);
        state_d   = DONE;
        cmd_vld_d = 1'b0;
        wd_d      = '0;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end

    // Outputs are registered from the next state so they change with it.
    dat_rdy_d = (state_d == DATA1) || (state_d == DATA2);
    sts_rdy_d = (state_d == STS1) || (state_d == STS2);
    done_d    = (state_d == DONE);
    pass_d    = (state_d == DONE) && (err_d == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_vld_q  <= 1'b0;
      cmd_data_q <= '0;
      dat_rdy_q  <= 1'b0;
      sts_rdy_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 8'd0;
      idx_q      <= 5'd0;
      a_q        <= '0;
      b_q        <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_data_q <= cmd_data_d;
      dat_rdy_q  <= dat_rdy_d;
      sts_rdy_q  <= sts_rdy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      wd_q       <= wd_d;
    end
  end

  assign ap_done = done_q;
  assign ap_pass = pass_q;
  assign err_cnt = err_q;
  assign bus.s_axis_mm2s_cmd_tvalid = cmd_vld_q;
  assign bus.s_axis_mm2s_cmd_tdata  = cmd_data_q;
  assign bus.m_axis_mm2s_tready     = dat_rdy_q;
  assign bus.m_axis_mm2s_sts_tready = sts_rdy_q;

endmodule

// File: tb/tb_fib_mm2s_reader.sv
module tb_fib_mm2s_reader;
  localparam int TIMEOUT = 1024;
  localparam logic [103:0] CMD1_EXP = {8'h00, 64'h0000_0000_0A00_0000, 8'h40, 1'b1, 23'd256};
  localparam logic [103:0] CMD2_EXP = {8'h00, 64'h0000_0000_0010_0000, 8'h40, 1'b1, 23'd544};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ap_start = 1'b0;
  logic ap_done, ap_pass;
  logic [7:0] err_cnt;

  fib_mm2s_reader_if bus ();

  fib_mm2s_reader #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_pass(ap_pass), .err_cnt(err_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    int         corrupt_idx;   // beat whose data is forced to 0 (-1 none)
    int         keep_bad_idx;  // beat with a cleared tkeep bit (-1 none)
    int         tlast_extra;   // beat carrying a spurious tlast (-1 none)
    int         tlast_miss;    // beat missing its tlast (-1 none)
    logic [7:0] sts1;
    logic [7:0] sts2;
    int         gaps;          // max random idle cycles before each beat
    int         cmd_stall;     // cycles cmd_tready held low in CMD1
    logic [7:0] exp_err;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[7];
  logic [255:0] fib[25];
  logic [103:0] cmd_q[$];
  logic [8:0]   res_q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input int stall);
    logic [103:0] exp, first;
    logic ok;
    int t;
    exp = (cmd_q.size() > 0) ? cmd_q.pop_front() : '0;
    t = 0;
    while (!bus.s_axis_mm2s_cmd_tvalid && t < 50) begin step(); t++; end
    check("cmd_tvalid_seen", bus.s_axis_mm2s_cmd_tvalid, 1);
    if (stall > 0) begin
      first = bus.s_axis_mm2s_cmd_tdata;
      ok = 1'b1;
      repeat (stall) begin
        step();
        if (!bus.s_axis_mm2s_cmd_tvalid || bus.s_axis_mm2s_cmd_tdata !== first) ok = 1'b0;
      end
      check("cmd_hold", ok, 1);
    end
    check("cmd_tdata", bus.s_axis_mm2s_cmd_tdata, exp);
    bus.s_axis_mm2s_cmd_tready = 1'b1;
    step();
    bus.s_axis_mm2s_cmd_tready = 1'b0;
    check("cmd_one_handshake", bus.s_axis_mm2s_cmd_tvalid, 0);
  endtask

  task automatic do_beats(input int lo, input int hi, input int last_idx, input vec_t v);
    int t;
    for (int i = lo; i <= hi; i++) begin
      repeat ($urandom_range(0, v.gaps)) step();
      bus.m_axis_mm2s_tvalid = 1'b1;
      bus.m_axis_mm2s_tdata  = (i == v.corrupt_idx) ? 256'd0 : fib[i];
      bus.m_axis_mm2s_tkeep  = (i == v.keep_bad_idx) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
      bus.m_axis_mm2s_tlast  = (i == v.tlast_extra) ? 1'b1 :
                               (i == v.tlast_miss)  ? 1'b0 : (i == 7 || i == 24);
      t = 0;
      while (!bus.m_axis_mm2s_tready && t < 50) begin step(); t++; end
      check($sformatf("beat%0d_ready", i), bus.m_axis_mm2s_tready, 1);
      step();
      bus.m_axis_mm2s_tvalid = 1'b0;
      // DATA must end exactly after the final beat of the transfer.
      check($sformatf("beat%0d_stay", i), bus.m_axis_mm2s_tready, (i != last_idx));
    end
  endtask

  task automatic do_sts(input logic [7:0] s);
    int t;
    t = 0;
    while (!bus.m_axis_mm2s_sts_tready && t < 50) begin step(); t++; end
    check("sts_ready", bus.m_axis_mm2s_sts_tready, 1);
    bus.m_axis_mm2s_sts_tvalid = 1'b1;
    bus.m_axis_mm2s_sts_tdata  = s;
    step();
    bus.m_axis_mm2s_sts_tvalid = 1'b0;
  endtask

  task automatic finish_run(input int bound, output int lat);
    logic [8:0] r;
    lat = 0;
    while (!ap_done && lat < bound) begin step(); lat++; end
    check("done_seen", ap_done, 1);
    r = (res_q.size() > 0) ? res_q.pop_front() : 9'h1FF;
    check("err_cnt", err_cnt, r[8:1]);
    check("ap_pass", ap_pass, r[0]);
    step(); step();
    check("done_hold", ap_done, 1);
    ap_start = 1'b0;
    step();
    check("done_drop", ap_done, 0);
  endtask

  task automatic run_case(input vec_t v);
    int lat;
    cmd_q.push_back(CMD1_EXP);
    cmd_q.push_back(CMD2_EXP);
    res_q.push_back({v.exp_err, v.exp_pass});
    ap_start = 1'b1;
    do_cmd(v.cmd_stall);
    do_beats(0, 7, 7, v);
    do_sts(v.sts1);
    do_cmd(0);
    do_beats(8, 24, 24, v);
    do_sts(v.sts2);
    finish_run(50, lat);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int lat;
    logic seen;
    bus.s_axis_mm2s_cmd_tready = 1'b0;
    bus.m_axis_mm2s_tvalid     = 1'b0;
    bus.m_axis_mm2s_tdata      = '0;
    bus.m_axis_mm2s_tkeep      = '0;
    bus.m_axis_mm2s_tlast      = 1'b0;
    bus.m_axis_mm2s_sts_tvalid = 1'b0;
    bus.m_axis_mm2s_sts_tdata  = '0;

    fib[0] = '0;
    fib[1] = 256'd1;
    for (int i = 2; i < 25; i++) fib[i] = fib[i-1] + fib[i-2];

    //         id corr keep xtra miss  sts1   sts2  gaps stall err pass
    vecs[0] = '{0, -1,  -1,  -1,  -1, 8'h80, 8'h80, 0,   0,   8'd0, 1'b1};
    vecs[1] = '{1, -1,  -1,  -1,  -1, 8'h80, 8'h80, 0,   5,   8'd0, 1'b1};
    vecs[2] = '{2, 12,  -1,  -1,  -1, 8'h80, 8'h80, 3,   0,   8'd1, 1'b0};
    vecs[3] = '{3, -1,  -1,   5,   7, 8'h80, 8'h80, 0,   0,   8'd2, 1'b0};
    vecs[4] = '{4, -1,  -1,  -1,  -1, 8'h80, 8'h40, 0,   0,   8'd1, 1'b0};
    vecs[5] = '{5, 20,  20,  -1,  -1, 8'h80, 8'h80, 1,   0,   8'd1, 1'b0};
    vecs[6] = '{6, -1,  -1,  -1,  -1, 8'h8F, 8'h90, 0,   2,   8'd1, 1'b0};

    repeat (3) step();
    check("rst_ap_done", ap_done, 0);
    check("rst_ap_pass", ap_pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_cmd_tvalid", bus.s_axis_mm2s_cmd_tvalid, 0);
    check("rst_tready", bus.m_axis_mm2s_tready, 0);
    check("rst_sts_tready", bus.m_axis_mm2s_sts_tready, 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[k]) run_case(vecs[k]);

    // No data after the second command: watchdog abort.
    v = vecs[0];
    cmd_q.push_back(CMD1_EXP);
    cmd_q.push_back(CMD2_EXP);
    res_q.push_back({8'd1, 1'b0});
    ap_start = 1'b1;
    do_cmd(0);
    do_beats(0, 7, 7, v);
    do_sts(8'h80);
    do_cmd(0);
    finish_run(TIMEOUT + 100, lat);
    check("timeout_latency", lat, TIMEOUT);
    step();

    // Reset in the middle of transfer 2.
    v = vecs[0];
    v.corrupt_idx = 9;
    cmd_q.push_back(CMD1_EXP);
    cmd_q.push_back(CMD2_EXP);
    ap_start = 1'b1;
    do_cmd(0);
    do_beats(0, 7, 7, v);
    do_sts(8'h80);
    do_cmd(0);
    do_beats(8, 10, 24, v);
    check("pre_rst_err_cnt", err_cnt, 1);
    rst_n = 1'b0;
    ap_start = 1'b0;
    step();
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_ap_done", ap_done, 0);
    check("midrst_ap_pass", ap_pass, 0);
    check("midrst_tready", bus.m_axis_mm2s_tready, 0);
    check("midrst_cmd_tdata", bus.s_axis_mm2s_cmd_tdata, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (bus.s_axis_mm2s_cmd_tvalid || bus.m_axis_mm2s_tready) seen = 1'b1;
    end
    check("idle_after_rst", seen, 0);

    // A clean run after the abort.
    run_case(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
